// File: rtl/dca_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dca_lsu_pkg
// Shared definitions for the DCA load/store unit request path:
//   - AXI read-address constants (INCR burst type, 4 KB page boundary)
//   - txn-info word layout {last_of_inst, last_of_row, alen, bitaddr}
//   - matrix-load request sequencer state enum
// -----------------------------------------------------------------------------
package dca_lsu_pkg;

    // AXI constants
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         AXI_4K_BYTES   = 4096;
    localparam int         AXI_4K_BITS    = 12;
    localparam int         BW_ALEN        = 8;

    // Bit offset inside one AXI data beat needs clog2(data width) bits.
    function automatic int calc_bw_bitaddr(input int bw_axi_data);
        return $clog2(bw_axi_data);
    endfunction

    // txn-info word: {last_of_inst, last_of_row, alen[7:0], bitaddr}
    function automatic int calc_bw_txn_info(input int bw_axi_data);
        return 2 + BW_ALEN + calc_bw_bitaddr(bw_axi_data);
    endfunction

    // Layout for the default 32-bit AXI data path.
    localparam int BW_BITADDR       = calc_bw_bitaddr(32);
    localparam int BW_TXN_INFO      = calc_bw_txn_info(32);
    localparam int TXN_BITADDR_LSB  = 0;
    localparam int TXN_ALEN_LSB     = BW_BITADDR;
    localparam int TXN_LAST_ROW_BIT = BW_BITADDR + BW_ALEN;
    localparam int TXN_LAST_INST_BIT = BW_BITADDR + BW_ALEN + 1;

    // Request sequencer FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/dca_lsu_burst_calc.sv
// -----------------------------------------------------------------------------
// dca_lsu_burst_calc
// Purely combinational segment calculation for one AXI read burst.
// Given the current byte address inside a row and the bytes still to fetch
// for that row, produces the next burst that stays within MAX_BURST_LEN
// beats and does not cross a 4 KB page.
//
// Ports:
//   row_addr_i     current (possibly unaligned) byte address in the row
//   rem_bytes_i    bytes still to fetch for this row (never zero)
//   araddr_o       beat-aligned burst address
//   alen_o         burst beats - 1
//   bitaddr_o      bit offset of the first useful byte in the first beat
//   seg_bytes_o    useful bytes covered by this burst
//   last_of_row_o  this burst finishes the row
// -----------------------------------------------------------------------------
module dca_lsu_burst_calc
    import dca_lsu_pkg::*;
#(
    parameter int BW_ADDR       = 32,
    parameter int BW_AXI_DATA   = 32,
    parameter int BW_REM        = 5,
    parameter int MAX_BURST_LEN = 16,
    parameter int BW_BITADDR    = $clog2(BW_AXI_DATA)
) (
    input  logic [BW_ADDR-1:0]    row_addr_i,
    input  logic [BW_REM-1:0]     rem_bytes_i,
    output logic [BW_ADDR-1:0]    araddr_o,
    output logic [BW_ALEN-1:0]    alen_o,
    output logic [BW_BITADDR-1:0] bitaddr_o,
    output logic [BW_REM-1:0]     seg_bytes_o,
    output logic                  last_of_row_o
);

    localparam int BB     = BW_AXI_DATA / 8;
    localparam int BW_OFF = $clog2(BB);
    // Wide enough for rem_bytes + offset and for a full 4 KB page in beats.
    localparam int W      = BW_REM + AXI_4K_BITS + 2;

    logic [BW_OFF-1:0]      off;
    logic [AXI_4K_BITS-1:0] page_off;
    logic [W-1:0]           off_w;
    logic [W-1:0]           rem_w;
    logic [W-1:0]           beats_need;
    logic [W-1:0]           beats_4k;
    logic [W-1:0]           beats_cap;
    logic [W-1:0]           beats;
    logic [W-1:0]           seg_cap;
    logic [W-1:0]           seg;

    assign off       = row_addr_i[BW_OFF-1:0];
    assign araddr_o  = {row_addr_i[BW_ADDR-1:BW_OFF], {BW_OFF{1'b0}}};
    assign bitaddr_o = BW_BITADDR'({off, 3'b000});
    assign page_off  = araddr_o[AXI_4K_BITS-1:0];

    assign off_w      = W'(off);
    assign rem_w      = W'(rem_bytes_i);
    assign beats_need = (off_w + rem_w + W'(BB - 1)) >> BW_OFF;
    // araddr is beat aligned, so the page remainder divides exactly.
    assign beats_4k   = (W'(AXI_4K_BYTES) - W'(page_off)) >> BW_OFF;

    always_comb begin
        beats_cap = (beats_need < beats_4k) ? beats_need : beats_4k;
        beats     = (beats_cap < W'(MAX_BURST_LEN)) ? beats_cap : W'(MAX_BURST_LEN);
        // The first beat loses 'off' bytes to the unaligned start.
        seg_cap   = (beats << BW_OFF) - off_w;
        seg       = (rem_w < seg_cap) ? rem_w : seg_cap;
    end

    assign alen_o        = BW_ALEN'(beats - W'(1));
    assign seg_bytes_o   = BW_REM'(seg);
    assign last_of_row_o = (seg == rem_w);

endmodule

// File: rtl/dca_matrix_load_req_sequencer.sv
// -----------------------------------------------------------------------------
// dca_matrix_load_req_sequencer
// Drives the AXI read-address channel for one DCA matrix-load instruction at a
// time. Rows are walked at base + r*stride; each row is split into bursts at
// the max-burst-length and 4 KB boundaries. Every issued burst also pushes a
// txn-info word {last_of_inst, last_of_row, alen, bitaddr} to the queue that
// feeds the load-response unformatter.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_valid / inst_ready       instruction handshake (ready only in IDLE)
//   inst_addr, inst_stride        matrix base byte address, row stride
//   inst_num_row_m1/_num_col_m1   rows-1, cols-1
//   arvalid/arready/araddr/arlen/arsize/arburst   AXI AR channel
//   txn_full, txn_push, txn_info  txn-info queue interface
//   busy                          instruction in progress
//   done                          one-cycle pulse after the final AR handshake
// -----------------------------------------------------------------------------
module dca_matrix_load_req_sequencer
    import dca_lsu_pkg::*;
#(
    parameter int BW_ADDR        = 32,
    parameter int BW_AXI_DATA    = 32,
    parameter int BW_ELEMENT     = 32,
    parameter int MATRIX_NUM_ROW = 4,
    parameter int MATRIX_NUM_COL = 4,
    parameter int MAX_BURST_LEN  = 16,
    parameter int BW_NUM_ROW     = $clog2(MATRIX_NUM_ROW),
    parameter int BW_NUM_COL     = $clog2(MATRIX_NUM_COL),
    parameter int BW_BITADDR     = calc_bw_bitaddr(BW_AXI_DATA),
    parameter int BW_TXN_INFO    = calc_bw_txn_info(BW_AXI_DATA)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_valid,
    output logic                   inst_ready,
    input  logic [BW_ADDR-1:0]     inst_addr,
    input  logic [BW_ADDR-1:0]     inst_stride,
    input  logic [BW_NUM_ROW-1:0]  inst_num_row_m1,
    input  logic [BW_NUM_COL-1:0]  inst_num_col_m1,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [BW_ADDR-1:0]     araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    input  logic                   txn_full,
    output logic                   txn_push,
    output logic [BW_TXN_INFO-1:0] txn_info,
    output logic                   busy,
    output logic                   done
);

    localparam int BB     = BW_AXI_DATA / 8;
    localparam int EB     = BW_ELEMENT / 8;
    localparam int BW_OFF = $clog2(BB);
    localparam int BW_REM = $clog2(MATRIX_NUM_COL * EB + 1);

    seq_state_e              state_q, state_d;
    logic [BW_ADDR-1:0]      row_base_q, row_base_d;
    logic [BW_ADDR-1:0]      row_addr_q, row_addr_d;
    logic [BW_ADDR-1:0]      stride_q, stride_d;
    logic [BW_NUM_ROW-1:0]   num_row_m1_q, num_row_m1_d;
    logic [BW_NUM_COL-1:0]   num_col_m1_q, num_col_m1_d;
    logic [BW_NUM_ROW-1:0]   row_cnt_q, row_cnt_d;
    logic [BW_REM-1:0]       rem_q, rem_d;
    logic [BW_ADDR-1:0]      araddr_q, araddr_d;
    logic [BW_ALEN-1:0]      alen_q, alen_d;
    logic [BW_BITADDR-1:0]   bitaddr_q, bitaddr_d;
    logic [BW_REM-1:0]       seg_q, seg_d;
    logic                    lor_q, lor_d;
    logic                    loi_q, loi_d;
    logic                    arvalid_q, arvalid_d;
    logic                    done_q, done_d;

    logic [BW_ADDR-1:0]      calc_araddr;
    logic [BW_ALEN-1:0]      calc_alen;
    logic [BW_BITADDR-1:0]   calc_bitaddr;
    logic [BW_REM-1:0]       calc_seg;
    logic                    calc_lor;
    logic [BW_REM-1:0]       inst_row_bytes;
    logic [BW_REM-1:0]       cur_row_bytes;
    logic                    handshake;

    dca_lsu_burst_calc #(
        .BW_ADDR       (BW_ADDR),
        .BW_AXI_DATA   (BW_AXI_DATA),
        .BW_REM        (BW_REM),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BW_BITADDR    (BW_BITADDR)
    ) u_burst_calc (
        .row_addr_i    (row_addr_q),
        .rem_bytes_i   (rem_q),
        .araddr_o      (calc_araddr),
        .alen_o        (calc_alen),
        .bitaddr_o     (calc_bitaddr),
        .seg_bytes_o   (calc_seg),
        .last_of_row_o (calc_lor)
    );

    // Bytes per row, for a freshly offered instruction and for the latched one.
    assign inst_row_bytes = (BW_REM'(inst_num_col_m1) + BW_REM'(1)) * BW_REM'(EB);
    assign cur_row_bytes  = (BW_REM'(num_col_m1_q) + BW_REM'(1)) * BW_REM'(EB);

    assign handshake = arvalid_q & arready;

    always_comb begin
        state_d      = state_q;
        row_base_d   = row_base_q;
        row_addr_d   = row_addr_q;
        stride_d     = stride_q;
        num_row_m1_d = num_row_m1_q;
        num_col_m1_d = num_col_m1_q;
        row_cnt_d    = row_cnt_q;
        rem_d        = rem_q;
        araddr_d     = araddr_q;
        alen_d       = alen_q;
        bitaddr_d    = bitaddr_q;
        seg_d        = seg_q;
        lor_d        = lor_q;
        loi_d        = loi_q;
        arvalid_d    = arvalid_q;
        done_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    row_base_d   = inst_addr;
                    row_addr_d   = inst_addr;
                    stride_d     = inst_stride;
                    num_row_m1_d = inst_num_row_m1;
                    num_col_m1_d = inst_num_col_m1;
                    row_cnt_d    = '0;
                    rem_d        = inst_row_bytes;
                    state_d      = ST_CALC;
                end
            end

            ST_CALC: begin
                // Freeze the segment so AR and txn fields stay stable while stalled.
                araddr_d  = calc_araddr;
                alen_d    = calc_alen;
                bitaddr_d = calc_bitaddr;
                seg_d     = calc_seg;
                lor_d     = calc_lor;
                loi_d     = calc_lor & (row_cnt_q == num_row_m1_q);
                arvalid_d = ~txn_full;
                state_d   = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (!arvalid_q) begin
                    // Hold off until the txn queue has room for this burst's info.
                    arvalid_d = ~txn_full;
                end else if (arready) begin
                    arvalid_d = 1'b0;
                    if (loi_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (lor_q) begin
                        // Step from the row base so unaligned splits never skew the stride.
                        row_cnt_d  = row_cnt_q + BW_NUM_ROW'(1);
                        row_base_d = row_base_q + stride_q;
                        row_addr_d = row_base_q + stride_q;
                        rem_d      = cur_row_bytes;
                        state_d    = ST_CALC;
                    end else begin
                        row_addr_d = row_addr_q + BW_ADDR'(seg_q);
                        rem_d      = rem_q - seg_q;
                        state_d    = ST_CALC;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_base_q   <= '0;
            row_addr_q   <= '0;
            stride_q     <= '0;
            num_row_m1_q <= '0;
            num_col_m1_q <= '0;
            row_cnt_q    <= '0;
            rem_q        <= '0;
            araddr_q     <= '0;
            alen_q       <= '0;
            bitaddr_q    <= '0;
            seg_q        <= '0;
            lor_q        <= 1'b0;
            loi_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_base_q   <= row_base_d;
            row_addr_q   <= row_addr_d;
            stride_q     <= stride_d;
            num_row_m1_q <= num_row_m1_d;
            num_col_m1_q <= num_col_m1_d;
            row_cnt_q    <= row_cnt_d;
            rem_q        <= rem_d;
            araddr_q     <= araddr_d;
            alen_q       <= alen_d;
            bitaddr_q    <= bitaddr_d;
            seg_q        <= seg_d;
            lor_q        <= lor_d;
            loi_q        <= loi_d;
            arvalid_q    <= arvalid_d;
            done_q       <= done_d;
        end
    end

    assign inst_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arlen      = alen_q;
    assign arsize     = 3'(BW_OFF);
    assign arburst    = AXI_BURST_INCR;
    assign txn_push   = handshake;
    assign txn_info   = {loi_q, lor_q, alen_q, bitaddr_q};

endmodule

// File: tb/tb_dca_matrix_load_req_sequencer.sv
module tb_dca_matrix_load_req_sequencer;

    localparam int MAXBL = 4;
    localparam int BB    = 4;
    localparam int EB    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [31:0] inst_stride;
    logic [1:0]  inst_num_row_m1;
    logic [1:0]  inst_num_col_m1;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        txn_full;
    logic        txn_push;
    logic [14:0] txn_info;
    logic        busy;
    logic        done;

    dca_matrix_load_req_sequencer #(
        .BW_ADDR(32), .BW_AXI_DATA(32), .BW_ELEMENT(32),
        .MATRIX_NUM_ROW(4), .MATRIX_NUM_COL(4), .MAX_BURST_LEN(MAXBL)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_addr(inst_addr), .inst_stride(inst_stride),
        .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .txn_full(txn_full), .txn_push(txn_push), .txn_info(txn_info),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [4:0]  bitaddr;
        logic        lor;
        logic        loi;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic exp_done_next = 1'b0;
    logic rand_en = 1'b0;

    logic        prev_arvalid = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_rst = 1'b1;
    logic        prev_txn_full = 1'b0;
    logic [31:0] prev_araddr = '0;
    logic [7:0]  prev_arlen = '0;
    logic [14:0] prev_txn_info = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input logic [31:0] a, input int alen, input int bitaddr,
                                     input logic lor, input logic loi);
        exp_t e;
        e.addr = a; e.alen = 8'(alen); e.bitaddr = 5'(bitaddr); e.lor = lor; e.loi = loi;
        exp_q.push_back(e);
    endfunction

    // Reference: walk rows and cut each into bursts by the three limits.
    function automatic void push_model(input logic [31:0] base, input logic [31:0] stride,
                                       input int rm1, input int cm1);
        logic [31:0] a;
        logic [31:0] ab;
        int rem, off, need, b4k, beats, seg;
        for (int r = 0; r <= rm1; r++) begin
            a   = base + 32'(r) * stride;
            rem = (cm1 + 1) * EB;
            while (rem > 0) begin
                off   = int'(a % 32'(BB));
                ab    = a - 32'(off);
                need  = (off + rem + BB - 1) / BB;
                b4k   = (4096 - int'(ab % 32'd4096)) / BB;
                beats = need;
                if (b4k < beats) beats = b4k;
                if (MAXBL < beats) beats = MAXBL;
                seg = beats * BB - off;
                if (rem < seg) seg = rem;
                push_exp(ab, beats - 1, off * 8, seg == rem, (seg == rem) && (r == rm1));
                a   = a + 32'(seg);
                rem = rem - seg;
            end
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            exp_done_next = 1'b0;
        end else begin
            chk("done_pulse", done, exp_done_next);
            exp_done_next = 1'b0;
            if (!prev_rst && prev_arvalid && !prev_hs) begin
                chk("stall_arvalid", arvalid, 1);
                chk("stall_araddr", araddr, prev_araddr);
                chk("stall_arlen", arlen, prev_arlen);
                chk("stall_txn_info", txn_info, prev_txn_info);
            end
            if (!prev_rst && !prev_arvalid && arvalid)
                chk("arvalid_rise_txn_full", prev_txn_full, 0);
            if (arvalid && arready) begin
                chk("txn_push_on_hs", txn_push, 1);
                chk("arsize", arsize, 3'd2);
                chk("arburst", arburst, 2'b01);
                chk("no_4k_cross", (int'(araddr % 32'd4096) + (int'(arlen) + 1) * BB) <= 4096, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_burst_addr", araddr, 32'hDEAD_BEEF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("araddr", araddr, mon_e.addr);
                    chk("arlen", arlen, mon_e.alen);
                    chk("txn_info", txn_info, {mon_e.loi, mon_e.lor, mon_e.alen, mon_e.bitaddr});
                    if (mon_e.loi) exp_done_next = 1'b1;
                end
            end else begin
                chk("txn_push_idle", txn_push, 0);
            end
        end
        prev_rst      = rst;
        prev_arvalid  = arvalid;
        prev_hs       = arvalid & arready;
        prev_txn_full = txn_full;
        prev_araddr   = araddr;
        prev_arlen    = arlen;
        prev_txn_info = txn_info;
    end

    // Random AR/txn backpressure driver
    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            arready = ($urandom_range(0, 3) != 0);
            if (!arvalid) txn_full = ($urandom_range(0, 3) == 0);
            else          txn_full = 1'b0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] s, input int rm1, input int cm1);
        int n;
        n = 0;
        while (!inst_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!inst_ready) chk("inst_ready_timeout", inst_ready, 1);
        inst_valid      = 1'b1;
        inst_addr       = a;
        inst_stride     = s;
        inst_num_row_m1 = 2'(rm1);
        inst_num_col_m1 = 2'(cm1);
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) begin
            chk("completion_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_arvalid();
        int n;
        n = 0;
        while (!arvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!arvalid) chk("arvalid_timeout", arvalid, 1);
    endtask

    logic [31:0] ra, rs, hold_addr;
    logic [7:0]  hold_len;

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst_addr = '0; inst_stride = '0;
        inst_num_row_m1 = '0; inst_num_col_m1 = '0; arready = 1'b0; txn_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_done", done, 0);
        chk("rst_txn_push", txn_push, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two aligned rows, with first-request latency
        arready = 1'b1;
        push_exp(32'h1000, 3, 0, 1'b1, 1'b0);
        push_exp(32'h1010, 3, 0, 1'b1, 1'b1);
        issue(32'h1000, 32'd16, 1, 3);
        chk("latency_calc_cycle", arvalid, 0);
        chk("busy_after_accept", busy, 1);
        @(posedge clk); #1;
        chk("latency_first_arvalid", arvalid, 1);
        wait_idle();

        // Unaligned start split by max burst length; inst_valid while busy is ignored
        push_exp(32'h1000, 3, 16, 1'b0, 1'b0);
        push_exp(32'h1010, 0, 0, 1'b1, 1'b1);
        issue(32'h1002, 32'd0, 0, 3);
        inst_valid = 1'b1; inst_addr = 32'h5000;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        wait_idle();

        // 4 KB boundary split
        push_exp(32'h1FF8, 1, 0, 1'b0, 1'b0);
        push_exp(32'h2000, 1, 0, 1'b1, 1'b1);
        issue(32'h1FF8, 32'd0, 0, 3);
        wait_idle();

        // arready held low: request must stay put
        arready = 1'b0;
        push_exp(32'h1000, 3, 0, 1'b1, 1'b0);
        push_exp(32'h1010, 3, 0, 1'b1, 1'b1);
        issue(32'h1000, 32'd16, 1, 3);
        wait_arvalid();
        hold_addr = araddr; hold_len = arlen;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, hold_addr);
            chk("bp_arlen", arlen, hold_len);
            chk("bp_txn_push", txn_push, 0);
        end
        arready = 1'b1;
        wait_idle();

        // txn queue full at ISSUE entry; stride 0x40 single-element rows
        txn_full = 1'b1;
        push_exp(32'h00, 0, 0, 1'b1, 1'b0);
        push_exp(32'h40, 0, 0, 1'b1, 1'b0);
        push_exp(32'h80, 0, 0, 1'b1, 1'b0);
        push_exp(32'hC0, 0, 0, 1'b1, 1'b1);
        issue(32'h0, 32'h40, 3, 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("full_arvalid_low", arvalid, 0);
        end
        txn_full = 1'b0;
        wait_idle();

        // Reset after the first handshake of a 4-row instruction
        push_exp(32'h3000, 3, 0, 1'b1, 1'b0);
        issue(32'h3000, 32'h20, 3, 3);
        wait_arvalid();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_arvalid", arvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_inst_ready", inst_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_first_burst_seen", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(32'h3000, 3, 0, 1'b1, 1'b0);
        push_exp(32'h3020, 3, 0, 1'b1, 1'b1);
        issue(32'h3000, 32'h20, 1, 3);
        wait_idle();

        // Randomized instructions with random backpressure
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[11:4] = 8'hFF;
            case ($urandom_range(0, 3))
                0:       rs = 32'h0;
                1:       rs = 32'($urandom_range(0, 64));
                2:       rs = $urandom;
                default: rs = 32'h1000 - 32'($urandom_range(0, 8));
            endcase
            begin
                int rm1, cm1;
                rm1 = $urandom_range(0, 3);
                cm1 = $urandom_range(0, 3);
                push_model(ra, rs, rm1, cm1);
                issue(ra, rs, rm1, cm1);
            end
            wait_idle();
        end
        rand_en = 1'b0;
        arready = 1'b0;
        txn_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
